// File: rtl/noc_pkg.sv
// Shared definitions for the tree NoC: port ids, packet field offsets and the route rule.
package noc_pkg;

   typedef enum logic [1:0] {
      C1 = 2'd0,
      C2 = 2'd1,
      P  = 2'd2
   } port_e;

   localparam int unsigned NUM_PORTS = 3;

   // Packet layout, MSB first: flag | dest | src | data
   function automatic int unsigned src_lsb(input int unsigned addr_w, input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned dest_lsb(input int unsigned addr_w, input int unsigned data_w);
      return data_w + addr_w;
   endfunction

   function automatic int unsigned flag_bit(input int unsigned addr_w, input int unsigned data_w);
      return data_w + 2 * addr_w;
   endfunction

   // True when the top LEVEL bits of dest equal those of this node's address (LEVEL=0 always matches)
   function automatic logic prefix_match(input logic [31:0] dest, input logic [31:0] node_addr,
                                         input int unsigned addr_w, input int unsigned level);
      logic m;
      m = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((i < addr_w) && ((i + level) >= addr_w) && (dest[i[4:0]] != node_addr[i[4:0]])) begin
            m = 1'b0;
         end
      end
      return m;
   endfunction

   // Downward traffic always follows bit k; upward traffic leaves the subtree unless the prefix matches
   function automatic port_e route(input logic [31:0] dest, input port_e from_port,
                                   input logic [31:0] node_addr, input int unsigned level,
                                   input int unsigned addr_w);
      int unsigned k;
      port_e       child;
      k     = addr_w - 1 - level;
      child = dest[k[4:0]] ? C2 : C1;
      if (from_port == P) begin
         return child;
      end
      if (!prefix_match(dest, node_addr, addr_w, level)) begin
         return P;
      end
      return child;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input packet FIFO with registered ready; wrap handled by one extra pointer bit.
module router_fifo #(
   parameter int unsigned WIDTH = 47,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic             empty_c_o,
   output logic [WIDTH-1:0] head_c_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic             rdy_q, rdy_d;
   logic             push_ok, pop_ok, empty, full_d;

   // Pointer and ready next-state; a full FIFO refuses pushes even while popping
   always_comb begin
      empty   = (wr_q == rd_q);
      push_ok = push_i && rdy_q;
      pop_ok  = pop_i && !empty;
      wr_d    = wr_q + PW'(push_ok);
      rd_d    = rd_q + PW'(pop_ok);
      full_d  = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);
      rdy_d   = !full_d;
   end

   // Pointer/ready state; ready stays low while reset is held
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         rdy_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         rdy_q <= rdy_d;
      end
   end

   // Storage array; contents are meaningless once pointers are reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

   assign ready_o   = rdy_q;
   assign empty_c_o = empty;
   assign head_c_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/tree_router_sync.sv
// Buffered three-port tree router node: per-input FIFOs, per-output round-robin and output register.
module tree_router_sync
   import noc_pkg::*;
#(
   parameter int unsigned        ADDR_W = 3,
   parameter int unsigned        DATA_W = 40,
   parameter logic [ADDR_W-1:0]  ADDR   = 3'b100,
   parameter int unsigned        LEVEL  = 1,
   parameter int unsigned        DEPTH  = 4,
   localparam int unsigned       PKT_W  = 1 + 2 * ADDR_W + DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c1_in_valid,
   output logic             c1_in_ready,
   input  logic [PKT_W-1:0] c1_in_data,
   input  logic             c2_in_valid,
   output logic             c2_in_ready,
   input  logic [PKT_W-1:0] c2_in_data,
   input  logic             p_in_valid,
   output logic             p_in_ready,
   input  logic [PKT_W-1:0] p_in_data,
   output logic             c1_out_valid,
   input  logic             c1_out_ready,
   output logic [PKT_W-1:0] c1_out_data,
   output logic             c2_out_valid,
   input  logic             c2_out_ready,
   output logic [PKT_W-1:0] c2_out_data,
   output logic             p_out_valid,
   input  logic             p_out_ready,
   output logic [PKT_W-1:0] p_out_data
);

   localparam int unsigned DEST_LSB = dest_lsb(ADDR_W, DATA_W);

   logic             in_valid  [NUM_PORTS];
   logic [PKT_W-1:0] in_data   [NUM_PORTS];
   logic             in_rdy    [NUM_PORTS];
   logic             fifo_pop  [NUM_PORTS];
   logic             fifo_empty[NUM_PORTS];
   logic [PKT_W-1:0] fifo_head [NUM_PORTS];
   port_e            tgt       [NUM_PORTS];
   logic             out_rdy   [NUM_PORTS];
   logic             out_vld   [NUM_PORTS];
   logic [PKT_W-1:0] out_dat   [NUM_PORTS];
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_mx;

   assign in_valid[0] = c1_in_valid;
   assign in_valid[1] = c2_in_valid;
   assign in_valid[2] = p_in_valid;
   assign in_data[0]  = c1_in_data;
   assign in_data[1]  = c2_in_data;
   assign in_data[2]  = p_in_data;
   assign c1_in_ready = in_rdy[0];
   assign c2_in_ready = in_rdy[1];
   assign p_in_ready  = in_rdy[2];
   assign out_rdy[0]  = c1_out_ready;
   assign out_rdy[1]  = c2_out_ready;
   assign out_rdy[2]  = p_out_ready;
   assign c1_out_valid = out_vld[0];
   assign c2_out_valid = out_vld[1];
   assign p_out_valid  = out_vld[2];
   assign c1_out_data  = out_dat[0];
   assign c2_out_data  = out_dat[1];
   assign p_out_data   = out_dat[2];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      assign fifo_pop[gi] = gnt_mx[0][gi] | gnt_mx[1][gi] | gnt_mx[2][gi];

      router_fifo #(
         .WIDTH (PKT_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push_i    (in_valid[gi]),
         .data_i    (in_data[gi]),
         .pop_i     (fifo_pop[gi]),
         .ready_o   (in_rdy[gi]),
         .empty_c_o (fifo_empty[gi]),
         .head_c_o  (fifo_head[gi])
      );
   end

   // Destination output of each FIFO head
   always_comb begin
      tgt[0] = route(32'(fifo_head[0][DEST_LSB +: ADDR_W]), C1, 32'(ADDR), LEVEL, ADDR_W);
      tgt[1] = route(32'(fifo_head[1][DEST_LSB +: ADDR_W]), C2, 32'(ADDR), LEVEL, ADDR_W);
      tgt[2] = route(32'(fifo_head[2][DEST_LSB +: ADDR_W]), P,  32'(ADDR), LEVEL, ADDR_W);
   end

   // Parent traffic must belong to this subtree; it is still routed by bit k if not
   always_ff @(posedge clk) begin
      if (!reset && !fifo_empty[2]) begin
         assert (prefix_match(32'(fifo_head[2][DEST_LSB +: ADDR_W]), 32'(ADDR), ADDR_W, LEVEL));
      end
   end

   for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
      localparam port_e OUT_ID = port_e'(2'(go));

      logic [1:0]           ptr_q, ptr_d;
      logic                 vld_q, vld_d;
      logic [PKT_W-1:0]     dat_q, dat_d;
      logic [NUM_PORTS-1:0] gnt;
      logic                 found;
      logic [1:0]           idx;
      int unsigned          sum;

      // Round-robin pick starting at the pointer, loaded only when the register can accept
      always_comb begin
         ptr_d = ptr_q;
         vld_d = vld_q;
         dat_d = dat_q;
         gnt   = '0;
         found = 1'b0;
         idx   = 2'd0;
         sum   = 0;
         if (!vld_q || out_rdy[go]) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
               sum = (32'(ptr_q) + j) % NUM_PORTS;
               idx = 2'(sum);
               if (!found && !fifo_empty[idx] && (tgt[idx] == OUT_ID)) begin
                  found    = 1'b1;
                  gnt[idx] = 1'b1;
                  dat_d    = fifo_head[idx];
                  vld_d    = 1'b1;
                  ptr_d    = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
               end
            end
            if (!found) begin
               vld_d = 1'b0;
            end
         end
      end

      // Output register and arbiter pointer
      always_ff @(posedge clk) begin
         if (reset) begin
            ptr_q <= 2'd0;
            vld_q <= 1'b0;
            dat_q <= '0;
         end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      assign gnt_mx[go]  = gnt;
      assign out_vld[go] = vld_q;
      assign out_dat[go] = dat_q;
   end

endmodule

// File: tb/tb_tree_router_sync.sv
// Self-checking bench for tree_router_sync (ADDR=3'b100, LEVEL=1, DEPTH=4).
module tb_tree_router_sync;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [46:0] in_data   [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [46:0] out_data  [3];

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          seqn     = 0;

   logic [46:0] pend  [3][$];
   logic [46:0] expq  [9][$];
   logic [46:0] capq  [3][$];
   int          capcyc[3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tree_router_sync dut (
      .clk          (clk),
      .reset        (reset),
      .c1_in_valid  (in_valid[0]),
      .c1_in_ready  (in_ready[0]),
      .c1_in_data   (in_data[0]),
      .c2_in_valid  (in_valid[1]),
      .c2_in_ready  (in_ready[1]),
      .c2_in_data   (in_data[1]),
      .p_in_valid   (in_valid[2]),
      .p_in_ready   (in_ready[2]),
      .p_in_data    (in_data[2]),
      .c1_out_valid (out_valid[0]),
      .c1_out_ready (out_ready[0]),
      .c1_out_data  (out_data[0]),
      .c2_out_valid (out_valid[1]),
      .c2_out_ready (out_ready[1]),
      .c2_out_data  (out_data[1]),
      .p_out_valid  (out_valid[2]),
      .p_out_ready  (out_ready[2]),
      .p_out_data   (out_data[2])
   );

   // Capture every egress transfer together with the cycle it completes in
   always @(negedge clk) begin
      if (!reset) begin
         for (int o = 0; o < 3; o++) begin
            if (out_valid[o] && out_ready[o]) begin
               capq[o].push_back(out_data[o]);
               capcyc[o].push_back(cyc);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference route for node 3'b100, LEVEL 1: prefix is dest bit 2, steering bit is dest bit 1
   function automatic int exp_out(input int src_port, input int dest);
      int steer;
      steer = (dest / 2) % 2;
      if (src_port == 2) return steer;
      if ((dest / 4) != 1) return 2;
      return steer;
   endfunction

   // Packet with random flag/src/payload; data[1:0] carries the ingress port, data[9:2] a sequence tag
   function automatic logic [46:0] mk(input int port, input int dest);
      logic [39:0] d;
      d = 40'({$urandom(), 8'(seqn), 2'(port)});
      seqn++;
      return {1'($urandom_range(0, 1)), 3'(dest), 3'($urandom_range(0, 7)), d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_out_ready(input logic v);
      for (int o = 0; o < 3; o++) out_ready[o] = v;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;
         pend[i].delete();
      end
      repeat (n) tick();
      reset = 1'b0;
      for (int k = 0; k < 9; k++) expq[k].delete();
      for (int o = 0; o < 3; o++) begin
         capq[o].delete();
         capcyc[o].delete();
      end
   endtask

   // Present pending packets on all ingress ports until accepted; record each acceptance in the scoreboard
   task automatic run(input int max_cyc, input bit rnd);
      int          n;
      bit          acc[3];
      logic [46:0] pkt;
      n = 0;
      while (n < max_cyc && (pend[0].size() + pend[1].size() + pend[2].size()) != 0) begin
         for (int i = 0; i < 3; i++) begin
            if (pend[i].size() != 0) begin
               in_valid[i] = 1'b1;
               in_data[i]  = pend[i][0];
            end else begin
               in_valid[i] = 1'b0;
            end
            acc[i] = in_valid[i] && in_ready[i];
         end
         if (rnd) for (int o = 0; o < 3; o++) out_ready[o] = 1'($urandom_range(0, 1));
         tick();
         n++;
         for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
               pkt = pend[i].pop_front();
               expq[i * 3 + exp_out(i, int'(pkt[45:43]))].push_back(pkt);
            end
         end
      end
      for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
      chk("run_all_accepted", 64'(pend[0].size() + pend[1].size() + pend[2].size()), 64'(0));
   endtask

   // Let outputs empty, then match every captured packet against its input/output pair queue
   task automatic drain_check(input string tag);
      logic [46:0] pkt;
      int          k;
      set_out_ready(1'b1);
      repeat (30) tick();
      for (int o = 0; o < 3; o++) begin
         while (capq[o].size() != 0) begin
            pkt = capq[o].pop_front();
            void'(capcyc[o].pop_front());
            k = int'(pkt[1:0]) * 3 + o;
            if (k > 8) k = 8;
            chk({tag, "_expected_here"}, 64'(expq[k].size() != 0), 64'(1));
            if (expq[k].size() != 0) chk({tag, "_pkt"}, 64'(pkt), 64'(expq[k].pop_front()));
         end
      end
      for (int j = 0; j < 9; j++) chk({tag, "_left_undelivered"}, 64'(expq[j].size()), 64'(0));
   endtask

   initial begin
      logic [46:0] pa;
      reset = 1'b1;
      set_out_ready(1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = '0;
      end

      // Step 1: reset for two cycles
      repeat (2) tick();
      for (int o = 0; o < 3; o++) begin
         chk("rst_out_valid", 64'(out_valid[o]), 64'(0));
         chk("rst_out_data", 64'(out_data[o]), 64'(0));
         chk("rst_in_ready", 64'(in_ready[o]), 64'(0));
      end
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) chk("post_rst_in_ready", 64'(in_ready[i]), 64'(1));

      // Step 2: parent to C1 with latency check, then parent to C2
      pa = mk(2, 3'b101);
      in_valid[2] = 1'b1;
      in_data[2]  = pa;
      tick();
      in_valid[2] = 1'b0;
      expq[2 * 3 + 0].push_back(pa);
      chk("lat_not_yet", 64'(out_valid[0]), 64'(0));
      tick();
      chk("lat_valid", 64'(out_valid[0]), 64'(1));
      chk("lat_data", 64'(out_data[0]), 64'(pa));
      pend[2].push_back(mk(2, 3'b110));
      run(50, 1'b0);
      drain_check("p_down");

      // Step 3: child up-route, cross-route and U-turn
      pend[0].push_back(mk(0, 3'b001));
      pend[0].push_back(mk(0, 3'b111));
      pend[1].push_back(mk(1, 3'b110));
      run(50, 1'b0);
      drain_check("child_routes");

      // Step 4: three streams into c2_out, fresh arbiter pointers
      do_reset(2);
      tick();
      for (int n = 0; n < 6; n++) begin
         pend[0].push_back(mk(0, 3'b111));
         pend[1].push_back(mk(1, 3'b110));
         pend[2].push_back(mk(2, 3'b111));
      end
      run(200, 1'b0);
      repeat (30) tick();
      chk("stream_count", 64'(capq[1].size()), 64'(18));
      for (int j = 0; j < 18; j++) begin
         if (j < capq[1].size()) begin
            chk("stream_rr_order", 64'(capq[1][j][1:0]), 64'(j % 3));
            chk("stream_back_to_back", 64'(capcyc[1][j] - capcyc[1][0]), 64'(j));
         end
      end
      drain_check("stream");

      // Step 5: back-pressure on p_out
      out_ready[2] = 1'b0;
      for (int n = 0; n < 5; n++) pend[0].push_back(mk(0, 3'b001));
      run(50, 1'b0);
      chk("bp_c1_in_ready_low", 64'(in_ready[0]), 64'(0));
      repeat (3) tick();
      chk("bp_hold_ready_low", 64'(in_ready[0]), 64'(0));
      chk("bp_hold_valid", 64'(out_valid[2]), 64'(1));
      chk("bp_hold_data", 64'(out_data[2]), 64'(expq[0 * 3 + 2][0]));
      chk("bp_nothing_out", 64'(capq[2].size()), 64'(0));
      drain_check("backpressure");

      // Step 6: move the c2_out pointer off C1, queue traffic, then reset over it
      pend[0].push_back(mk(0, 3'b111));
      run(50, 1'b0);
      drain_check("pre_reset");
      out_ready[2] = 1'b0;
      for (int n = 0; n < 3; n++) pend[0].push_back(mk(0, 3'b001));
      run(50, 1'b0);
      tick();
      reset = 1'b1;
      repeat (2) tick();
      chk("midrst_p_valid", 64'(out_valid[2]), 64'(0));
      do_reset(0);
      set_out_ready(1'b1);
      repeat (5) tick();
      for (int o = 0; o < 3; o++) begin
         chk("after_rst_no_valid", 64'(out_valid[o]), 64'(0));
         chk("after_rst_no_output", 64'(capq[o].size()), 64'(0));
      end
      pend[0].push_back(mk(0, 3'b111));
      pend[1].push_back(mk(1, 3'b110));
      pend[2].push_back(mk(2, 3'b111));
      run(50, 1'b0);
      repeat (10) tick();
      chk("rr_restart_count", 64'(capq[1].size()), 64'(3));
      for (int j = 0; j < 3; j++) begin
         if (j < capq[1].size()) chk("rr_restart_order", 64'(capq[1][j][1:0]), 64'(j));
      end
      drain_check("rr_restart");

      // Step 7: random traffic with random output back-pressure
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 30; n++) begin
            pend[i].push_back(mk(i, (i == 2) ? 4 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 7))));
         end
      end
      run(3000, 1'b1);
      drain_check("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
